// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: state encoding, digit limits
// and a constant-evaluable clog2 for sizing counters.
package bcd_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         DIGIT_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int w = value - 1; w > 0; w = w >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction cell: a digit that reached 8 or more after the
// right shift has absorbed a weight-8 bit that really represents 5, so take 3 off.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd8) begin
            digit_o = digit_i - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter using shift-right / subtract-3, one
// result bit per clock, with start/busy/done handshake and an active-low output gate.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        g_n,
    input  logic                        start,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [BIN_W-1:0]            bin_out
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = (clog2(BIN_W) > 0) ? clog2(BIN_W) : 1;

    logic [1:0]       state_q, state_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [SCR_W-1:0] shifted;
    logic [SCR_W-1:0] adjusted;
    logic             bcd_ok;

    assign shifted = scratch_q >> 1;
    // The binary field below the digits only receives shifted-in bits; no correction.
    assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_i (shifted[BIN_W + gi*DIGIT_W +: DIGIT_W]),
            .digit_o (adjusted[BIN_W + gi*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
                bcd_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bcd_ok) begin
                        scratch_d = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d     = '0;
                        state_d   = SHIFT;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '1;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                scratch_d = adjusted;
                cnt_d     = cnt_q + 1'b1;
                // Result is captured on the final shift so it appears alongside done.
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    result_d = adjusted[BIN_W-1:0];
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign bin_out = g_n ? {BIN_W{1'b1}} : result_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed scenarios plus randomized operands
// checked against a decimal-arithmetic reference model.
module tb_bcd2bin_seq;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;
    localparam int BOUND  = 20;

    logic                  clk;
    logic                  rst_n;
    logic                  g_n;
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    int n_checks;
    int n_fail;

    bcd2bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g_n     (g_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, or an error flag if any digit exceeds 9.
    function automatic logic [7:0] ref_conv(input logic [4*DIGITS-1:0] b);
        int  v;
        bit  bad;
        int  d;
        v   = 0;
        bad = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'((b >> (4 * i)) & 4'hF);
            if (d > 9) bad = 1;
            v = v * 10 + d;
        end
        if (bad) return {1'b1, 7'h7F};
        return {1'b0, 7'(v)};
    endfunction

    // Called at the first falling edge after the accepting clock edge, start already low.
    task automatic wait_done(input string tag, input logic [4*DIGITS-1:0] bcd);
        logic [7:0] r;
        logic [6:0] exp_bin;
        int         c;
        int         busy_cnt;
        int         exp_lat;
        r        = ref_conv(bcd);
        exp_bin  = g_n ? 7'h7F : r[6:0];
        exp_lat  = r[7] ? 1 : BIN_W + 1;
        c        = 1;
        busy_cnt = 0;
        while (c <= BOUND) begin
            if (done) break;
            if (busy) busy_cnt++;
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), r[7] ? 32'd0 : 32'(BIN_W));
        chk({tag, "_bin_out"}, 32'(bin_out), 32'(exp_bin));
        chk({tag, "_err"}, 32'(err), 32'(r[7]));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_conv(input string tag, input logic [4*DIGITS-1:0] bcd);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 8'($urandom);
        wait_done(tag, bcd);
        @(negedge clk);
        chk({tag, "_single_pulse"}, 32'(done), 32'd0);
    endtask

    logic [4*DIGITS-1:0] rnd_bcd;
    logic [3:0]          dig;
    int                  dones;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        g_n      = 1'b0;
        start    = 1'b0;
        bcd_in   = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_bin_out", 32'(bin_out), 32'd0);
        rst_n = 1'b1;

        run_conv("basic_99", 8'h99);
        run_conv("zero", 8'h00);
        run_conv("seven", 8'h07);
        run_conv("ten", 8'h10);
        run_conv("sixty_three", 8'h63);
        run_conv("invalid_4a", 8'h4A);
        run_conv("after_invalid_25", 8'h25);

        // A start pulsed while busy must be ignored; one in the done cycle too.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h42;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h13;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 8'h00;
        dones  = 0;
        for (int c = 4; c <= BOUND; c++) begin
            if (done) begin
                dones++;
                break;
            end
            @(negedge clk);
        end
        chk("busy_start_done_seen", 32'(dones), 32'd1);
        chk("busy_start_bin_out", 32'(bin_out), 32'd42);
        start  = 1'b1;
        bcd_in = 8'h13;
        @(negedge clk);
        chk("done_cycle_start_ignored_busy", 32'(busy), 32'd0);
        chk("done_cycle_start_ignored_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done("restart_13", 8'h13);
        @(negedge clk);

        // Reset in the middle of a conversion aborts it immediately.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h88;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_bin_out", 32'(bin_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv("post_reset_05", 8'h05);

        // Output gate forces all ones but does not stop or corrupt the conversion.
        g_n = 1'b1;
        run_conv("gated_37", 8'h37);
        g_n = 1'b0;
        #1;
        chk("ungated_37", 32'(bin_out), 32'd37);

        for (int k = 0; k < 24; k++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 7) == 0) dig = 4'($urandom_range(10, 15));
                else dig = 4'($urandom_range(0, 9));
                rnd_bcd[4*d +: 4] = dig;
            end
            g_n = ($urandom_range(0, 3) == 0);
            run_conv($sformatf("rand%0d_%02h", k, rnd_bcd), rnd_bcd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
